l2_refill_ctrl: RTL and testbench

- Memory-side refill engine directly downstream of the L2 instruction cache controller.
- On an L2 miss it fetches one 512-bit block from main memory over a 128-bit burst bus, delivering the critical word first.
- It assembles the block in line order, presents it as L2 data-array write data, and pulses L2_complete so the L2 controller can re-access.
- A no-progress timeout aborts hung bursts.

---
 rtl/l2_refill_ctrl.sv | 133 +++++++++++++
 tb/tb_l2_refill_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_refill_ctrl.sv
// Refill engine below the L2 I-cache: fetches one 512-bit block as four 128-bit beats,
// critical word first, assembles it in line order and aborts bursts that stop making progress.
module l2_refill_ctrl #(
   parameter int BEATS       = 4,
   parameter int BEAT_W      = 128,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    refill_req,
   input  logic [25:0]             blk_addr,
   input  logic [1:0]              word_off,
   output logic                    busy,
   output logic                    bus_req,
   output logic [27:0]             bus_addr,
   input  logic                    bus_ack,
   input  logic                    bus_rvalid,
   input  logic [BEAT_W-1:0]       bus_rdata,
   output logic                    crit_valid,
   output logic [BEAT_W-1:0]       crit_data,
   output logic [BEATS*BEAT_W-1:0] L2_data_wd,
   output logic                    L2_complete,
   output logic                    refill_err
);

   // state | meaning
   // IDLE  | waiting for refill_req
   // REQ   | bus_req high, waiting for bus_ack
   // RECV  | collecting data beats
   // DONE  | block assembled, L2_complete high for one cycle
   typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYC - 1);
   localparam logic [1:0] BEAT_LAST = 2'(BEATS - 1);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] off_q;
   logic [1:0] beat_cnt;
   logic [1:0] slot;
   logic [7:0] tmo_cnt;
   logic       tmo_hit;

   assign tmo_hit = (tmo_cnt == TMO_LAST);
   assign slot    = off_q + beat_cnt;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (refill_req) state_nxt = REQ;
         REQ: begin
            if (bus_ack)      state_nxt = RECV;
            else if (tmo_hit) state_nxt = IDLE;
         end
         RECV: begin
            if (bus_rvalid) begin
               if (beat_cnt == BEAT_LAST) state_nxt = DONE;
            end else if (tmo_hit) begin
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // refill_err is still counted as busy so the abort completes before busy drops
   always_comb begin
      busy        = (state != IDLE) || refill_err;
      bus_req     = (state == REQ);
      L2_complete = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         off_q      <= '0;
         beat_cnt   <= '0;
         tmo_cnt    <= '0;
         bus_addr   <= '0;
         crit_valid <= 1'b0;
         crit_data  <= '0;
         L2_data_wd <= '0;
         refill_err <= 1'b0;
      end else begin
         crit_valid <= 1'b0;
         refill_err <= 1'b0;
         case (state)
            IDLE: begin
               if (refill_req) begin
                  bus_addr   <= {blk_addr, word_off};
                  off_q      <= word_off;
                  beat_cnt   <= '0;
                  tmo_cnt    <= '0;
                  L2_data_wd <= '0;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  tmo_cnt <= '0;
               end else if (tmo_hit) begin
                  tmo_cnt    <= '0;
                  refill_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            RECV: begin
               if (bus_rvalid) begin
                  L2_data_wd[slot*BEAT_W +: BEAT_W] <= bus_rdata;
                  if (beat_cnt == 2'd0) begin
                     crit_data  <= bus_rdata;
                     crit_valid <= 1'b1;
                  end
                  beat_cnt <= beat_cnt + 2'd1;
                  tmo_cnt  <= '0;
               end else if (tmo_hit) begin
                  tmo_cnt    <= '0;
                  refill_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_refill_ctrl.sv
// Self-checking bench for l2_refill_ctrl: table of refill vectors with a scoreboard for
// critical beat and assembled block, plus hand sequences for timeout and mid-burst reset.
module tb_l2_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         refill_req;
   logic [25:0]  blk_addr;
   logic [1:0]   word_off;
   logic         busy;
   logic         bus_req;
   logic [27:0]  bus_addr;
   logic         bus_ack;
   logic         bus_rvalid;
   logic [127:0] bus_rdata;
   logic         crit_valid;
   logic [127:0] crit_data;
   logic [511:0] L2_data_wd;
   logic         L2_complete;
   logic         refill_err;

   l2_refill_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .refill_req  (refill_req),
      .blk_addr    (blk_addr),
      .word_off    (word_off),
      .busy        (busy),
      .bus_req     (bus_req),
      .bus_addr    (bus_addr),
      .bus_ack     (bus_ack),
      .bus_rvalid  (bus_rvalid),
      .bus_rdata   (bus_rdata),
      .crit_valid  (crit_valid),
      .crit_data   (crit_data),
      .L2_data_wd  (L2_data_wd),
      .L2_complete (L2_complete),
      .refill_err  (refill_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [25:0]       blk;
      logic [1:0]        off;
      int                ack_dly;
      int                gap;
      bit                ack_rv;
      logic [3:0][127:0] beat;
      logic [511:0]      exp_wd;
   } vec_t;

   vec_t         vecs [4];
   logic [511:0] wd_q [$];
   logic [127:0] crit_q [$];
   int           n_vec = 0;
   int           n_bad = 0;
   int           n_cpl = 0;
   int           n_errp = 0;
   int           cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] pat(input logic [7:0] tag, input int i);
      return {tag, 8'(i), 112'h0123456789ABCDEFFEDCBA987654};
   endfunction

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {busy, bus_req, crit_valid, L2_complete, refill_err}, 0);
      chk({tag, "_bus_addr"}, bus_addr, 0);
      chk({tag, "_crit_data"}, crit_data, 0);
      chk({tag, "_wd"}, L2_data_wd, 0);
   endtask

   // scoreboard side: compare pulses against what the driver queued
   always @(posedge clk) begin
      #1;
      if (crit_valid) begin
         if (crit_q.size() == 0) chk("crit_pulse_expected", 512'(crit_q.size()), 512'd1);
         else                    chk("crit_data", crit_data, crit_q.pop_front());
      end
      if (L2_complete) begin
         n_cpl++;
         if (wd_q.size() == 0) chk("cpl_pulse_expected", 512'(wd_q.size()), 512'd1);
         else                  chk("L2_data_wd", L2_data_wd, wd_q.pop_front());
      end
      if (refill_err) n_errp++;
   end

   task automatic run_vec(input vec_t v);
      int c0;
      c0 = cyc;
      refill_req = 1'b1;
      blk_addr   = v.blk;
      word_off   = v.off;
      tick();
      refill_req = 1'b0;
      blk_addr   = '0;
      word_off   = '0;
      chk("req_busy", busy, 1);
      chk("req_bus_req", bus_req, 1);
      chk("req_bus_addr", bus_addr, {v.blk, v.off});
      wd_q.push_back(v.exp_wd);
      crit_q.push_back(v.beat[0]);
      for (int k = 0; k < v.ack_dly; k++) begin
         tick();
         chk("ack_wait_bus_req", bus_req, 1);
      end
      bus_ack = 1'b1;
      if (v.ack_rv) begin
         bus_rvalid = 1'b1;
         bus_rdata  = pat(8'hEE, 0);
      end
      tick();
      bus_ack    = 1'b0;
      bus_rvalid = 1'b0;
      chk("ack_drop_bus_req", bus_req, 0);
      for (int i = 0; i < 4; i++) begin
         bus_rvalid = 1'b1;
         bus_rdata  = v.beat[i];
         tick();
         bus_rvalid = 1'b0;
         bus_rdata  = pat(8'h55, i);
         if (i < 3) for (int g = 0; g < v.gap; g++) tick();
      end
      chk("cpl_pulse", L2_complete, 1);
      chk("cpl_latency", cyc - c0, 6 + v.ack_dly + 3 * v.gap);
      tick();
      chk("idle_busy", busy, 0);
      chk("cpl_once", L2_complete, 0);
      chk("wd_hold", L2_data_wd, v.exp_wd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{blk: 26'h0ABCDE, off: 2'd0, ack_dly: 0, gap: 0, ack_rv: 1'b0,
                  beat: '0, exp_wd: '0};
      vecs[1] = '{blk: 26'h1000040, off: 2'd2, ack_dly: 0, gap: 0, ack_rv: 1'b1,
                  beat: '0, exp_wd: '0};
      vecs[2] = '{blk: 26'h3FFFFFF, off: 2'd0, ack_dly: 10, gap: 3, ack_rv: 1'b0,
                  beat: '0, exp_wd: '0};
      vecs[3] = '{blk: 26'h1234567, off: 2'd3, ack_dly: 2, gap: 1, ack_rv: 1'b0,
                  beat: '0, exp_wd: '0};
      for (int i = 0; i < 4; i++) begin
         vecs[0].beat[i] = pat(8'hA0, i);
         vecs[1].beat[i] = pat(8'hB0, i);
         vecs[2].beat[i] = pat(8'hC0, i);
         vecs[3].beat[i] = pat(8'hD0, i);
      end
      vecs[0].exp_wd = {pat(8'hA0, 3), pat(8'hA0, 2), pat(8'hA0, 1), pat(8'hA0, 0)};
      vecs[1].exp_wd = {pat(8'hB0, 1), pat(8'hB0, 0), pat(8'hB0, 3), pat(8'hB0, 2)};
      vecs[2].exp_wd = {pat(8'hC0, 3), pat(8'hC0, 2), pat(8'hC0, 1), pat(8'hC0, 0)};
      vecs[3].exp_wd = {pat(8'hD0, 0), pat(8'hD0, 3), pat(8'hD0, 2), pat(8'hD0, 1)};

      rst        = 1'b0;
      refill_req = 1'b0;
      blk_addr   = '0;
      word_off   = '0;
      bus_ack    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;

      // reset held two cycles with requests and bus inputs toggling
      for (int k = 0; k < 2; k++) begin
         refill_req = 1'b1;
         blk_addr   = 26'h2AAAAAA;
         bus_ack    = ~bus_ack;
         bus_rvalid = ~bus_rvalid;
         bus_rdata  = {4{$urandom}};
         tick();
         check_zero("reset");
      end
      refill_req = 1'b0;
      bus_ack    = 1'b0;
      bus_rvalid = 1'b0;
      rst        = 1'b1;
      tick();
      chk("post_reset_idle", {busy, bus_req}, 0);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // no ack at all; rvalid chatter in REQ must not count as progress
      refill_req = 1'b1;
      blk_addr   = 26'h0000155;
      word_off   = 2'd1;
      tick();
      refill_req = 1'b0;
      n = 0;
      for (int k = 0; k < 300 && !refill_err; k++) begin
         if (bus_req) n++;
         bus_rvalid = ~bus_rvalid;
         bus_rdata  = pat(8'h77, k);
         tick();
      end
      bus_rvalid = 1'b0;
      chk("tmo_err_seen", refill_err, 1);
      chk("tmo_req_cycles", n, 255);
      chk("tmo_bus_req", bus_req, 0);
      chk("tmo_no_cpl", L2_complete, 0);
      tick();
      chk("tmo_busy_after", busy, 0);
      chk("tmo_err_once", refill_err, 0);

      run_vec(vecs[0]);

      // second request during RECV ignored, then reset after the third beat
      refill_req = 1'b1;
      blk_addr   = 26'h2A5A5A5;
      word_off   = 2'd1;
      tick();
      refill_req = 1'b0;
      chk("mid_bus_addr", bus_addr, {26'h2A5A5A5, 2'd1});
      bus_ack = 1'b1;
      crit_q.push_back(pat(8'hE0, 0));
      tick();
      bus_ack    = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = pat(8'hE0, 0);
      tick();
      bus_rdata  = pat(8'hE0, 1);
      refill_req = 1'b1;
      blk_addr   = 26'h0000001;
      word_off   = 2'd2;
      tick();
      refill_req = 1'b0;
      chk("recv_req_ignored_addr", bus_addr, {26'h2A5A5A5, 2'd1});
      chk("recv_busy", busy, 1);
      bus_rdata = pat(8'hE0, 2);
      tick();
      bus_rvalid = 1'b0;
      rst        = 1'b0;
      tick();
      check_zero("mid_reset");
      rst        = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata  = pat(8'hE0, 3);
      tick();
      check_zero("late_beat");
      tick();
      bus_rvalid = 1'b0;
      check_zero("late_beat2");
      tick();

      chk("cpl_count", n_cpl, 5);
      chk("err_count", n_errp, 1);
      chk("sb_drain", wd_q.size() + crit_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
